fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Sequences the combinational instruction memory: owns the PC and drives the memory address.
//  Captures each returned instruction word with its PC into a small FIFO.
//  Hands {pc, inst} to decode over a valid/ready handshake.
//  Sits between inst_mem and decode; applies branch/jump redirects and halt/resume control.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC loaded on reset
//  DEPTH     2              fetch FIFO entries (power of 2, >=2)
// PORTS
//  clk              in   1   clock, rising edge
//  reset            in   1   synchronous, active-high
//  inst_add         out  32  address to instruction memory (= PC register)
//  inst_code        in   32  instruction word from memory, valid same cycle as inst_add
//  redirect_valid   in   1   branch/jump taken this cycle
//  redirect_target  in   32  new PC; bits [1:0] are forced to 0 internally
//  halt_req         in   1   stop fetching (pulse)
//  resume           in   1   restart fetching from HALTED (pulse)
//  out_valid        out  1   FIFO head valid
//  out_ready        in   1   decode accepts head
//  out_inst         out  32  head instruction; 32'h0000_0013 (NOP) when empty
//  out_pc           out  32  head PC; 0 when empty
//  fetch_state      out  2   0=IDLE 1=FETCH 2=HALTED
//  retired_cnt      out  32  count of accepted handshakes, wraps at 2^32
// BEHAVIOUR
//  Reset (sync, overrides all inputs):
//   pc <= RESET_PC; FIFO emptied; state <= IDLE; retired_cnt <= 0.
//   Outputs next cycle: out_valid=0, out_inst=NOP, out_pc=0, inst_add=RESET_PC.
//  FSM:
//   IDLE   -> FETCH unconditionally after 1 cycle; no fetch in IDLE, redirect ignored.
//   FETCH  -> HALTED when halt_req=1.
//   HALTED -> FETCH when resume=1.
//   resume in FETCH/IDLE and halt_req in HALTED/IDLE are ignored.
//  Fetch (push) in a cycle when ALL hold:
//   state==FETCH; halt_req=0; redirect_valid=0; and (FIFO not full OR pop this cycle).
//   Push action: write {pc, inst_code}; pc <= pc+4, wrapping mod 2^32.
//  Pop: out_valid & out_ready; head advances, retired_cnt += 1.
//   Push and pop in the same cycle: occupancy unchanged, including when full.
//  Redirect (state FETCH or HALTED):
//   FIFO flushed, including the head offered that cycle.
//   A flushed head does not count even if out_ready=1.
//   pc <= {redirect_target[31:2],2'b00}; no push that cycle; state unaffected.
//   First redirected instruction appears at out_valid 2 cycles after the redirect cycle.
//  halt_req with redirect_valid: both apply (pc updated, state -> HALTED).
//  HALTED: no pushes; existing FIFO entries continue to drain normally; pc held.
//  Latency: PC presented in cycle N -> entry visible at out_* in cycle N+1.
//  Throughput: 1 instr/cycle sustained while out_ready=1.
//  out_* are driven from FIFO head registers only; no combinational path from inst_code to out_*.
//  inst_add is always the pc register (registered output).
// TESTING
//  1. Reset, out_ready=1, mem[i]=i*4+0x100 -> out_pc 0,4,8,... back-to-back;
//     out_valid first high 2 cycles after reset release.
//  2. out_ready=0 for 5 cycles -> FIFO fills to DEPTH, inst_add holds at 8, no loss or dup;
//     release -> pcs 0,4,8 in order.
//  3. Redirect to 32'h0000_0203 while FIFO full -> flush; next out_pc=0x200;
//     retired_cnt unchanged that cycle.
//  4. halt_req at pc=0x10 -> buffered entries drain, then out_valid=0, inst_add stays 0x10;
//     resume -> fetch continues at 0x10.
//  5. halt_req+redirect(0x40) same cycle -> state HALTED, inst_add=0x40;
//     resume -> first out_pc=0x40.
//  6. Reset asserted mid-stream with out_valid=1 -> next cycle out_valid=0, out_inst=NOP,
//     retired_cnt=0, inst_add=RESET_PC, fetch_state=IDLE.

Source files
------------

// File: rtl/fetch_sequencer.sv
// ---------------------------------------------------------------------------
// fetch_sequencer
//
// Purpose:
//   This block owns the program counter and drives the address of a
//   combinational instruction memory. Each returned word is captured with
//   its PC into a small FIFO. The FIFO head is handed to decode over a
//   valid/ready handshake. Branch/jump redirects flush the FIFO and reload
//   the PC. Halt and resume pulses stop and restart fetching.
//
// Parameters:
//   RESET_PC  PC loaded on reset
//   DEPTH     fetch FIFO entries (power of 2, >= 2)
//
// Ports:
//   clk              in   1   clock, rising edge
//   reset            in   1   synchronous, active-high
//   inst_add         out  32  instruction memory address (the PC register)
//   inst_code        in   32  instruction word for inst_add, same cycle
//   redirect_valid   in   1   branch/jump taken this cycle
//   redirect_target  in   32  new PC (bits [1:0] ignored)
//   halt_req         in   1   stop fetching (pulse)
//   resume           in   1   restart fetching from HALTED (pulse)
//   out_valid        out  1   FIFO head valid
//   out_ready        in   1   decode accepts head
//   out_inst         out  32  head instruction, NOP when empty
//   out_pc           out  32  head PC, 0 when empty
//   fetch_state      out  2   0=IDLE 1=FETCH 2=HALTED
//   retired_cnt      out  32  accepted handshakes, wraps at 2^32
// ---------------------------------------------------------------------------
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] inst_add,
    input  logic [31:0] inst_code,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    input  logic        halt_req,
    input  logic        resume,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc,
    output logic [1:0]  fetch_state,
    output logic [31:0] retired_cnt
);

    localparam int unsigned AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   retired_q, retired_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic [31:0]   fifo_pc_q   [DEPTH];
    logic [31:0]   fifo_inst_q [DEPTH];

    logic empty;
    logic full;
    logic flush;
    logic pop;
    logic push;

    // Handshake and fetch decisions for this cycle.
    always_comb begin
        empty = (count_q == '0);
        full  = (count_q == CNT_FULL);
        // Redirects are only honoured once the sequencer has left IDLE.
        flush = redirect_valid && (state_q != IDLE);
        // A head that is being flushed is never counted as accepted.
        pop   = !empty && out_ready && !flush;
        // A full FIFO still accepts a push when the head leaves this cycle.
        push  = (state_q == FETCH) && !halt_req && !redirect_valid &&
                (!full || pop);
    end

    // Next-state logic for control, PC, pointers and counters.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;

        unique case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   if (halt_req) state_d = HALTED;
            HALTED:  if (resume)   state_d = FETCH;
            default: state_d = IDLE;
        endcase

        if (pop) begin
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
            retired_d = retired_q + 32'd1;
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
            pc_d     = pc_q + 32'd4;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            pc_d     = {redirect_target[31:2], 2'b00};
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments so
    // every register samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            retired_q <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
        end
    end

    // NOTE: the FIFO storage has no reset; an entry is only observable
    // once count_q covers it, so clearing the pointers is sufficient.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifo_pc_q[wr_ptr_q]   <= pc_q;
            fifo_inst_q[wr_ptr_q] <= inst_code;
        end
    end

    // Outputs come only from registers: no path from inst_code to out_*.
    always_comb begin
        inst_add    = pc_q;
        out_valid   = !empty;
        out_inst    = empty ? NOP   : fifo_inst_q[rd_ptr_q];
        out_pc      = empty ? 32'd0 : fifo_pc_q[rd_ptr_q];
        fetch_state = state_q;
        retired_cnt = retired_q;
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// tb_fetch_sequencer
//
// Directed stimulus for fetch_sequencer. The instruction memory is modelled
// as mem[i] = i*4 + 0x100, i.e. the word at address a is a + 0x100.
// A queue-based model predicts every output each cycle; literal checks in
// the stimulus pin the model to hand-computed values.
// ---------------------------------------------------------------------------
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    localparam int M_IDLE   = 0;
    localparam int M_FETCH  = 1;
    localparam int M_HALTED = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] inst_add;
    logic [31:0] inst_code;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        halt_req;
    logic        resume;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [1:0]  fetch_state;
    logic [31:0] retired_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // Combinational instruction memory.
    assign inst_code = inst_add + 32'h0000_0100;

    fetch_sequencer #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .inst_add        (inst_add),
        .inst_code       (inst_code),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .halt_req        (halt_req),
        .resume          (resume),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_inst        (out_inst),
        .out_pc          (out_pc),
        .fetch_state     (fetch_state),
        .retired_cnt     (retired_cnt)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: a queue of {pc, inst}, a PC and a mode number.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    entry_t      m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_ret;
    int          m_mode;
    bit          m_live = 1'b0;

    always @(posedge clk) begin
        bit     do_flush;
        bit     do_pop;
        bit     do_push;
        entry_t e;
        if (reset) begin
            m_q.delete();
            m_pc   = RESET_PC;
            m_ret  = 32'd0;
            m_mode = M_IDLE;
            m_live = 1'b1;
        end else if (m_live) begin
            do_flush = redirect_valid && (m_mode != M_IDLE);
            do_pop   = (m_q.size() != 0) && out_ready && !do_flush;
            do_push  = (m_mode == M_FETCH) && !halt_req && !redirect_valid &&
                       ((m_q.size() < DEPTH) || do_pop);
            e.pc     = m_pc;
            e.inst   = m_pc + 32'h0000_0100;
            if (do_flush) m_q.delete();
            else if (do_pop) void'(m_q.pop_front());
            if (do_pop) m_ret = m_ret + 32'd1;
            if (do_push) begin
                m_q.push_back(e);
                m_pc = m_pc + 32'd4;
            end
            if (do_flush) m_pc = redirect_target & 32'hFFFF_FFFC;
            case (m_mode)
                M_IDLE:   m_mode = M_FETCH;
                M_FETCH:  if (halt_req) m_mode = M_HALTED;
                M_HALTED: if (resume) m_mode = M_FETCH;
                default:  m_mode = M_IDLE;
            endcase
        end
    end

    // Compare process: every cycle once the model has seen a reset.
    always @(negedge clk) begin
        if (m_live) begin
            check("mdl_valid", 32'(out_valid), 32'(m_q.size() != 0));
            check("mdl_pc", out_pc, (m_q.size() != 0) ? m_q[0].pc : 32'd0);
            check("mdl_inst", out_inst, (m_q.size() != 0) ? m_q[0].inst : NOP);
            check("mdl_add", inst_add, m_pc);
            check("mdl_state", 32'(fetch_state), 32'(m_mode));
            check("mdl_ret", retired_cnt, m_ret);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Watchdog: the stimulus is fixed-length, this only guards a hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset           = 1'b1;
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;
        halt_req        = 1'b0;
        resume          = 1'b0;
        out_ready       = 1'b1;
        tick();
        tick();

        // Reset state.
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_inst", out_inst, NOP);
        check("rst_pc", out_pc, 32'd0);
        check("rst_add", inst_add, RESET_PC);
        check("rst_state", 32'(fetch_state), 32'd0);
        check("rst_ret", retired_cnt, 32'd0);

        // 1. Streaming with out_ready=1.
        reset = 1'b0;
        tick();
        check("t1_state", 32'(fetch_state), 32'd1);
        check("t1_valid0", 32'(out_valid), 32'd0);
        check("t1_add0", inst_add, 32'd0);
        tick();
        check("t1_valid1", 32'(out_valid), 32'd1);
        check("t1_pc0", out_pc, 32'd0);
        check("t1_inst0", out_inst, 32'h0000_0100);
        check("t1_add1", inst_add, 32'd4);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("t1_stream_pc", out_pc, 32'(4 * k));
            check("t1_stream_ret", retired_cnt, 32'(k));
            check("t1_stream_valid", 32'(out_valid), 32'd1);
        end

        // 6. Reset mid-stream with out_valid=1.
        reset = 1'b1;
        tick();
        check("t6_valid", 32'(out_valid), 32'd0);
        check("t6_inst", out_inst, NOP);
        check("t6_ret", retired_cnt, 32'd0);
        check("t6_add", inst_add, RESET_PC);
        check("t6_state", 32'(fetch_state), 32'd0);

        // 2. Back-pressure for 5 cycles, then release.
        reset     = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        tick();
        check("t2_add_full", inst_add, 32'd8);
        tick();
        tick();
        check("t2_add_hold", inst_add, 32'd8);
        check("t2_head", out_pc, 32'd0);
        check("t2_ret", retired_cnt, 32'd0);
        out_ready = 1'b1;
        tick();
        check("t2_pc4", out_pc, 32'd4);
        check("t2_ret1", retired_cnt, 32'd1);
        check("t2_add12", inst_add, 32'd12);
        tick();
        check("t2_pc8", out_pc, 32'd8);
        check("t2_ret2", retired_cnt, 32'd2);

        // 3. Redirect to 0x203 while full; head offered with ready=1 is dropped.
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0203;
        tick();
        check("t3_valid", 32'(out_valid), 32'd0);
        check("t3_ret", retired_cnt, 32'd2);
        check("t3_add", inst_add, 32'h0000_0200);
        redirect_valid = 1'b0;
        tick();
        check("t3_pc", out_pc, 32'h0000_0200);
        check("t3_inst", out_inst, 32'h0000_0300);
        check("t3_ret2", retired_cnt, 32'd2);

        // 4. Halt at pc=0x10 with two buffered entries, drain, resume.
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0008;
        tick();
        redirect_valid = 1'b0;
        out_ready      = 1'b0;
        tick();
        tick();
        check("t4_add10", inst_add, 32'h0000_0010);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check("t4_state", 32'(fetch_state), 32'd2);
        check("t4_add_h", inst_add, 32'h0000_0010);
        check("t4_head8", out_pc, 32'h0000_0008);
        out_ready = 1'b1;
        tick();
        check("t4_headc", out_pc, 32'h0000_000C);
        tick();
        check("t4_drained", 32'(out_valid), 32'd0);
        check("t4_ret", retired_cnt, 32'd4);
        tick();
        check("t4_still", 32'(out_valid), 32'd0);
        check("t4_add_hold", inst_add, 32'h0000_0010);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        check("t4_resumed", 32'(fetch_state), 32'd1);
        tick();
        check("t4_pc10", out_pc, 32'h0000_0010);
        check("t4_inst10", out_inst, 32'h0000_0110);

        // 5. halt_req and redirect(0x40) in the same cycle.
        halt_req        = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0040;
        tick();
        halt_req       = 1'b0;
        redirect_valid = 1'b0;
        check("t5_state", 32'(fetch_state), 32'd2);
        check("t5_add", inst_add, 32'h0000_0040);
        check("t5_valid", 32'(out_valid), 32'd0);
        check("t5_ret", retired_cnt, 32'd4);
        tick();
        check("t5_add_hold", inst_add, 32'h0000_0040);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        tick();
        check("t5_pc40", out_pc, 32'h0000_0040);
        check("t5_inst40", out_inst, 32'h0000_0140);

        // Redirect and halt during IDLE are ignored.
        reset = 1'b1;
        tick();
        reset           = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h0000_0080;
        halt_req        = 1'b1;
        tick();
        redirect_valid = 1'b0;
        halt_req       = 1'b0;
        check("idle_state", 32'(fetch_state), 32'd1);
        check("idle_add", inst_add, 32'd0);
        tick();
        check("idle_pc0", out_pc, 32'd0);

        // PC wraps modulo 2^32; target low bits are cleared.
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFE;
        tick();
        redirect_valid = 1'b0;
        check("wrap_add", inst_add, 32'hFFFF_FFFC);
        tick();
        check("wrap_add0", inst_add, 32'd0);
        check("wrap_pc", out_pc, 32'hFFFF_FFFC);
        check("wrap_inst", out_inst, 32'h0000_00FC);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
